// File: rtl/ctrl_pkg.sv
// Shared constants for the pipeline control chain.
// Holds the decoder ALU op codes, the MIPS primary opcodes the decoder
// recognises, and the EX operand forwarding select encoding.
package ctrl_pkg;

    // ALU operation codes produced by the ID-stage decoder
    localparam logic [2:0] ALUOP_ADD   = 3'b000;  // lw / sw address add
    localparam logic [2:0] ALUOP_SUB   = 3'b001;  // beq compare
    localparam logic [2:0] ALUOP_RTYPE = 3'b010;  // funct field decides
    localparam logic [2:0] ALUOP_ADDI  = 3'b110;
    localparam logic [2:0] ALUOP_SLTI  = 3'b111;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    // EX operand source select
    localparam logic [1:0] FWD_REG   = 2'b00;  // register file
    localparam logic [1:0] FWD_EXMEM = 2'b10;  // EX/MEM result
    localparam logic [1:0] FWD_MEMWB = 2'b01;  // MEM/WB result

endpackage

// File: rtl/ctrl_fwd_sel.sv
// Forwarding select for one EX-stage source operand.
// Ports:
//   src_i                    source register specifier of the EX instruction
//   mem_valid_i/regwrite_i   EX/MEM stage valid and register-write control
//   mem_dst_i                EX/MEM destination register
//   wb_valid_i/regwrite_i    MEM/WB stage valid and register-write control
//   wb_dst_i                 MEM/WB destination register
//   sel_o                    operand source select (ctrl_pkg FWD_*)
// The younger producer (EX/MEM) takes priority over MEM/WB.
module ctrl_fwd_sel
    import ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] src_i,
    input  logic                  mem_valid_i,
    input  logic                  mem_regwrite_i,
    input  logic [REG_ADDR_W-1:0] mem_dst_i,
    input  logic                  wb_valid_i,
    input  logic                  wb_regwrite_i,
    input  logic [REG_ADDR_W-1:0] wb_dst_i,
    output logic [1:0]            sel_o
);

    always_comb begin
        sel_o = FWD_REG;
        if (mem_valid_i && mem_regwrite_i && (mem_dst_i != '0) && (mem_dst_i == src_i)) begin
            sel_o = FWD_EXMEM;
        end else if (wb_valid_i && wb_regwrite_i && (wb_dst_i != '0) && (wb_dst_i == src_i)) begin
            sel_o = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/ctrl_pipe_chain.sv
// Control pipeline for the 5-stage MIPS core.
// Carries the decoder control bundle through ID/EX, EX/MEM and MEM/WB, and
// produces the load-use stall, the taken-branch flush and the EX forwarding
// selects.
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   id_*_i                  decoder controls and register fields of the ID instruction
//   ex_branch_taken_i       EX-stage branch comparison result
//   stall_o, flush_o        hold PC/IF-ID, squash IF-ID and redirect PC (combinational)
//   ex_*_o                  EX-stage controls and source specifiers
//   fwd_a_o, fwd_b_o        EX operand source selects (combinational)
//   mem_*_o, wb_*_o         MEM- and WB-stage controls and destinations
module ctrl_pipe_chain
    import ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned ALU_OP_W   = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  id_valid_i,
    input  logic                  id_regwrite_i,
    input  logic                  id_alusrc_i,
    input  logic                  id_regdst_i,
    input  logic                  id_branch_i,
    input  logic                  id_memtoreg_i,
    input  logic                  id_memread_i,
    input  logic                  id_memwrite_i,
    input  logic [ALU_OP_W-1:0]   id_aluop_i,
    input  logic [REG_ADDR_W-1:0] id_rs_i,
    input  logic [REG_ADDR_W-1:0] id_rt_i,
    input  logic [REG_ADDR_W-1:0] id_rd_i,
    input  logic                  ex_branch_taken_i,
    output logic                  stall_o,
    output logic                  flush_o,
    output logic [ALU_OP_W-1:0]   ex_aluop_o,
    output logic                  ex_alusrc_o,
    output logic                  ex_branch_o,
    output logic [REG_ADDR_W-1:0] ex_rs_o,
    output logic [REG_ADDR_W-1:0] ex_rt_o,
    output logic [1:0]            fwd_a_o,
    output logic [1:0]            fwd_b_o,
    output logic                  mem_memread_o,
    output logic                  mem_memwrite_o,
    output logic                  mem_regwrite_o,
    output logic [REG_ADDR_W-1:0] mem_dst_o,
    output logic                  wb_regwrite_o,
    output logic                  wb_memtoreg_o,
    output logic [REG_ADDR_W-1:0] wb_dst_o
);

    // ID/EX
    logic                  ex_valid_q, ex_regwrite_q, ex_alusrc_q, ex_branch_q;
    logic                  ex_memtoreg_q, ex_memread_q, ex_memwrite_q;
    logic [ALU_OP_W-1:0]   ex_aluop_q;
    logic [REG_ADDR_W-1:0] ex_rs_q, ex_rt_q, ex_dst_q;
    // EX/MEM
    logic                  mem_valid_q, mem_regwrite_q, mem_memtoreg_q;
    logic                  mem_memread_q, mem_memwrite_q;
    logic [REG_ADDR_W-1:0] mem_dst_q;
    // MEM/WB
    logic                  wb_valid_q, wb_regwrite_q, wb_memtoreg_q;
    logic [REG_ADDR_W-1:0] wb_dst_q;

    logic [REG_ADDR_W-1:0] id_dst;
    logic                  uses_rt, hazard, load_bubble;
    logic [1:0]            sel_a, sel_b;

    always_comb begin
        id_dst  = id_regdst_i ? id_rd_i : id_rt_i;
        // rt is a real source for R-type, stores (data) and beq (compare)
        uses_rt = !id_alusrc_i || id_memwrite_i || id_branch_i;
        hazard  = id_valid_i && ex_valid_q && ex_memread_q && (ex_dst_q != '0) &&
                  ((ex_dst_q == id_rs_i) || (uses_rt && (ex_dst_q == id_rt_i)));
        flush_o = ex_valid_q && ex_branch_q && ex_branch_taken_i;
        // A taken branch squashes the dependent instruction anyway
        stall_o = hazard && !flush_o;
        load_bubble = flush_o || stall_o || !id_valid_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex_valid_q     <= 1'b0;
            ex_regwrite_q  <= 1'b0;
            ex_alusrc_q    <= 1'b0;
            ex_branch_q    <= 1'b0;
            ex_memtoreg_q  <= 1'b0;
            ex_memread_q   <= 1'b0;
            ex_memwrite_q  <= 1'b0;
            ex_aluop_q     <= '0;
            ex_rs_q        <= '0;
            ex_rt_q        <= '0;
            ex_dst_q       <= '0;
            mem_valid_q    <= 1'b0;
            mem_regwrite_q <= 1'b0;
            mem_memtoreg_q <= 1'b0;
            mem_memread_q  <= 1'b0;
            mem_memwrite_q <= 1'b0;
            mem_dst_q      <= '0;
            wb_valid_q     <= 1'b0;
            wb_regwrite_q  <= 1'b0;
            wb_memtoreg_q  <= 1'b0;
            wb_dst_q       <= '0;
        end else begin
            if (load_bubble) begin
                ex_valid_q    <= 1'b0;
                ex_regwrite_q <= 1'b0;
                ex_alusrc_q   <= 1'b0;
                ex_branch_q   <= 1'b0;
                ex_memtoreg_q <= 1'b0;
                ex_memread_q  <= 1'b0;
                ex_memwrite_q <= 1'b0;
                ex_aluop_q    <= '0;
                ex_rs_q       <= '0;
                ex_rt_q       <= '0;
                ex_dst_q      <= '0;
            end else begin
                ex_valid_q    <= 1'b1;
                // $0 is never written, so drop the write at capture
                ex_regwrite_q <= id_regwrite_i && (id_dst != '0);
                ex_alusrc_q   <= id_alusrc_i;
                ex_branch_q   <= id_branch_i;
                ex_memtoreg_q <= id_memtoreg_i;
                ex_memread_q  <= id_memread_i;
                ex_memwrite_q <= id_memwrite_i;
                ex_aluop_q    <= id_aluop_i;
                ex_rs_q       <= id_rs_i;
                ex_rt_q       <= id_rt_i;
                ex_dst_q      <= id_dst;
            end
            mem_valid_q    <= ex_valid_q;
            mem_regwrite_q <= ex_regwrite_q;
            mem_memtoreg_q <= ex_memtoreg_q;
            mem_memread_q  <= ex_memread_q;
            mem_memwrite_q <= ex_memwrite_q;
            mem_dst_q      <= ex_dst_q;
            wb_valid_q     <= mem_valid_q;
            wb_regwrite_q  <= mem_regwrite_q;
            wb_memtoreg_q  <= mem_memtoreg_q;
            wb_dst_q       <= mem_dst_q;
        end
    end

    ctrl_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
        .src_i          (ex_rs_q),
        .mem_valid_i    (mem_valid_q),
        .mem_regwrite_i (mem_regwrite_q),
        .mem_dst_i      (mem_dst_q),
        .wb_valid_i     (wb_valid_q),
        .wb_regwrite_i  (wb_regwrite_q),
        .wb_dst_i       (wb_dst_q),
        .sel_o          (sel_a)
    );

    ctrl_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
        .src_i          (ex_rt_q),
        .mem_valid_i    (mem_valid_q),
        .mem_regwrite_i (mem_regwrite_q),
        .mem_dst_i      (mem_dst_q),
        .wb_valid_i     (wb_valid_q),
        .wb_regwrite_i  (wb_regwrite_q),
        .wb_dst_i       (wb_dst_q),
        .sel_o          (sel_b)
    );

    always_comb begin
        fwd_a_o = ex_valid_q ? sel_a : FWD_REG;
        fwd_b_o = ex_valid_q ? sel_b : FWD_REG;
    end

    assign ex_aluop_o     = ex_aluop_q;
    assign ex_alusrc_o    = ex_alusrc_q;
    assign ex_branch_o    = ex_branch_q;
    assign ex_rs_o        = ex_rs_q;
    assign ex_rt_o        = ex_rt_q;
    assign mem_memread_o  = mem_memread_q;
    assign mem_memwrite_o = mem_memwrite_q;
    assign mem_regwrite_o = mem_regwrite_q;
    assign mem_dst_o      = mem_dst_q;
    assign wb_regwrite_o  = wb_regwrite_q;
    assign wb_memtoreg_o  = wb_memtoreg_q;
    assign wb_dst_o       = wb_dst_q;

endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// Randomized bench for ctrl_pipe_chain against an instruction-level model:
// each pipeline stage of the model holds one whole decoded instruction.
module tb_ctrl_pipe_chain;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_regwrite, id_alusrc, id_regdst, id_branch;
    logic       id_memtoreg, id_memread, id_memwrite;
    logic [2:0] id_aluop;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       taken;
    logic       stall, flush, ex_alusrc, ex_branch;
    logic [2:0] ex_aluop;
    logic [4:0] ex_rs, ex_rt, mem_dst, wb_dst;
    logic [1:0] fwd_a, fwd_b;
    logic       mem_memread, mem_memwrite, mem_regwrite, wb_regwrite, wb_memtoreg;

    always #5 clk = ~clk;

    ctrl_pipe_chain #(.REG_ADDR_W(5), .ALU_OP_W(3)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .id_valid_i        (id_valid),
        .id_regwrite_i     (id_regwrite),
        .id_alusrc_i       (id_alusrc),
        .id_regdst_i       (id_regdst),
        .id_branch_i       (id_branch),
        .id_memtoreg_i     (id_memtoreg),
        .id_memread_i      (id_memread),
        .id_memwrite_i     (id_memwrite),
        .id_aluop_i        (id_aluop),
        .id_rs_i           (id_rs),
        .id_rt_i           (id_rt),
        .id_rd_i           (id_rd),
        .ex_branch_taken_i (taken),
        .stall_o           (stall),
        .flush_o           (flush),
        .ex_aluop_o        (ex_aluop),
        .ex_alusrc_o       (ex_alusrc),
        .ex_branch_o       (ex_branch),
        .ex_rs_o           (ex_rs),
        .ex_rt_o           (ex_rt),
        .fwd_a_o           (fwd_a),
        .fwd_b_o           (fwd_b),
        .mem_memread_o     (mem_memread),
        .mem_memwrite_o    (mem_memwrite),
        .mem_regwrite_o    (mem_regwrite),
        .mem_dst_o         (mem_dst),
        .wb_regwrite_o     (wb_regwrite),
        .wb_memtoreg_o     (wb_memtoreg),
        .wb_dst_o          (wb_dst)
    );

    // One in-flight instruction as the model sees it
    typedef struct packed {
        logic       v;
        logic       rw;
        logic       alusrc;
        logic       branch;
        logic       m2r;
        logic       mr;
        logic       mw;
        logic [2:0] aluop;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] dst;
    } ins_t;

    ins_t ex_m, mem_m, wb_m;
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [4:0] pick_reg();
        if ($urandom_range(0, 3) != 0) return 5'($urandom_range(0, 3));
        return 5'($urandom_range(0, 31));
    endfunction

    // Decoder behaviour for the six supported instruction kinds
    task automatic drive_id(input bit force_rtype);
        int kind;
        kind = force_rtype ? 0 : int'($urandom_range(0, 5));
        id_valid = force_rtype ? 1'b1 : ($urandom_range(0, 7) != 0);
        {id_regwrite, id_alusrc, id_regdst, id_branch} = '0;
        {id_memtoreg, id_memread, id_memwrite} = '0;
        id_rs = pick_reg();
        id_rt = pick_reg();
        id_rd = pick_reg();
        case (kind)
            0: begin id_regwrite = 1; id_regdst = 1; id_aluop = 3'b010; end
            1: begin id_regwrite = 1; id_alusrc = 1; id_aluop = 3'b110; end
            2: begin id_regwrite = 1; id_alusrc = 1; id_aluop = 3'b111; end
            3: begin
                id_regwrite = 1; id_alusrc = 1; id_memread = 1; id_memtoreg = 1;
                id_aluop = 3'b000;
            end
            4: begin id_alusrc = 1; id_memwrite = 1; id_aluop = 3'b000; end
            default: begin id_branch = 1; id_aluop = 3'b001; end
        endcase
        taken = force_rtype ? 1'b0 : 1'($urandom_range(0, 1));
    endtask

    function automatic logic exp_flush();
        return ex_m.v && ex_m.branch && taken;
    endfunction

    function automatic logic exp_stall();
        logic uses_rt, hz;
        uses_rt = !id_alusrc || id_memwrite || id_branch;
        hz = id_valid && ex_m.v && ex_m.mr && (ex_m.dst != 0) &&
             ((ex_m.dst == id_rs) || (uses_rt && (ex_m.dst == id_rt)));
        return hz && !exp_flush();
    endfunction

    function automatic logic [1:0] exp_fwd(input logic [4:0] src);
        if (!ex_m.v) return 2'b00;
        if (mem_m.v && mem_m.rw && mem_m.dst != 0 && mem_m.dst == src) return 2'b10;
        if (wb_m.v && wb_m.rw && wb_m.dst != 0 && wb_m.dst == src) return 2'b01;
        return 2'b00;
    endfunction

    // Instruction entering EX at the next edge
    function automatic ins_t capture();
        ins_t n;
        n = '0;
        if (!id_valid || exp_flush() || exp_stall()) return n;
        n.v      = 1'b1;
        n.alusrc = id_alusrc;
        n.branch = id_branch;
        n.m2r    = id_memtoreg;
        n.mr     = id_memread;
        n.mw     = id_memwrite;
        n.aluop  = id_aluop;
        n.rs     = id_rs;
        n.rt     = id_rt;
        n.dst    = id_regdst ? id_rd : id_rt;
        n.rw     = id_regwrite && (n.dst != 0);
        return n;
    endfunction

    task automatic check_outputs(input string ph);
        check_eq({ph, " stall"},        32'(stall),        32'(exp_stall()));
        check_eq({ph, " flush"},        32'(flush),        32'(exp_flush()));
        check_eq({ph, " ex_aluop"},     32'(ex_aluop),     32'(ex_m.aluop));
        check_eq({ph, " ex_alusrc"},    32'(ex_alusrc),    32'(ex_m.alusrc));
        check_eq({ph, " ex_branch"},    32'(ex_branch),    32'(ex_m.branch));
        check_eq({ph, " ex_rs"},        32'(ex_rs),        32'(ex_m.rs));
        check_eq({ph, " ex_rt"},        32'(ex_rt),        32'(ex_m.rt));
        check_eq({ph, " fwd_a"},        32'(fwd_a),        32'(exp_fwd(ex_m.rs)));
        check_eq({ph, " fwd_b"},        32'(fwd_b),        32'(exp_fwd(ex_m.rt)));
        check_eq({ph, " mem_memread"},  32'(mem_memread),  32'(mem_m.mr));
        check_eq({ph, " mem_memwrite"}, 32'(mem_memwrite), 32'(mem_m.mw));
        check_eq({ph, " mem_regwrite"}, 32'(mem_regwrite), 32'(mem_m.rw));
        check_eq({ph, " mem_dst"},      32'(mem_dst),      32'(mem_m.dst));
        check_eq({ph, " wb_regwrite"},  32'(wb_regwrite),  32'(wb_m.rw));
        check_eq({ph, " wb_memtoreg"},  32'(wb_memtoreg),  32'(wb_m.m2r));
        check_eq({ph, " wb_dst"},       32'(wb_dst),       32'(wb_m.dst));
    endtask

    initial begin
        ins_t nxt;
        rst = 1'b1;
        {id_valid, id_regwrite, id_alusrc, id_regdst, id_branch} = '0;
        {id_memtoreg, id_memread, id_memwrite, taken} = '0;
        id_aluop = '0; id_rs = '0; id_rt = '0; id_rd = '0;
        ex_m = '0; mem_m = '0; wb_m = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_outputs("reset");

        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge clk);
            rst = 1'b0;
            // First three cycles fill the pipe with R-types for the reset test
            drive_id(cyc < 3);
            #1;
            if (cyc == 3 || cyc == 400) begin
                // Asynchronous reset between edges discards everything in flight
                rst = 1'b1;
                ex_m = '0; mem_m = '0; wb_m = '0;
                #1;
                check_outputs("rst_mid");
                @(posedge clk);
                #1;
                check_outputs("rst_held");
                continue;
            end
            check_outputs("run");
            nxt = capture();
            @(posedge clk);
            wb_m  = mem_m;
            mem_m = ex_m;
            ex_m  = nxt;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
